// File: rtl/uart_rx_frame_deserializer_if.sv
// Handshake/bus bundle between the RX sampling stage, the frame deserializer and the RX top level.
interface uart_rx_frame_deserializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    // Sampling-stage side
    logic                  frame_start;
    logic                  bit_done;
    logic                  sampled_bit;
    // Frame configuration
    logic                  par_en;
    logic                  par_typ;
    // Result side
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;
    logic                  busy;

    // Upstream driver / RX top level
    modport master (
        output frame_start, bit_done, sampled_bit, par_en, par_typ,
        input  p_data, data_valid, par_err, stp_err, strt_glitch, busy
    );

    // The deserializer itself
    modport slave (
        input  frame_start, bit_done, sampled_bit, par_en, par_typ,
        output p_data, data_valid, par_err, stp_err, strt_glitch, busy
    );
endinterface

// File: rtl/uart_rx_frame_deserializer.sv
// UART RX frame deserializer: walks start / data (LSB-first) / optional parity / stop
// on voted bits, checks framing and parity, and publishes the received word.
module uart_rx_frame_deserializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_rx_frame_deserializer_if.slave bus
);
    localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  frame_bad_q, frame_bad_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  strt_glitch_q, strt_glitch_d;
    logic                  busy_q, busy_d;
    logic                  par_exp_c;

    // Parity bit the sender should have transmitted for the word collected so far
    assign par_exp_c = (^shreg_q) ^ par_typ_q;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            p_data_q      <= '0;
            bit_cnt_q     <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            frame_bad_q   <= 1'b0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            strt_glitch_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            p_data_q      <= p_data_d;
            bit_cnt_q     <= bit_cnt_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            frame_bad_q   <= frame_bad_d;
            data_valid_q  <= data_valid_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
            strt_glitch_q <= strt_glitch_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state: advance one frame field per bit_done
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bus.bit_done) begin
                    state_d = bus.sampled_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bus.bit_done && (bit_cnt_q == LAST_BIT)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bus.bit_done) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bus.bit_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values; pulses default low
    always_comb begin
        shreg_d       = shreg_q;
        p_data_d      = p_data_q;
        bit_cnt_d     = bit_cnt_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        frame_bad_d   = frame_bad_q;
        data_valid_d  = 1'b0;
        par_err_d     = 1'b0;
        stp_err_d     = 1'b0;
        strt_glitch_d = 1'b0;
        busy_d        = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    par_en_d    = bus.par_en;
                    par_typ_d   = bus.par_typ;
                    frame_bad_d = 1'b0;
                end
            end
            S_START: begin
                if (bus.bit_done) begin
                    bit_cnt_d = '0;
                    if (bus.sampled_bit) begin
                        strt_glitch_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (bus.bit_done) begin
                    shreg_d = {bus.sampled_bit, shreg_q[DATA_WIDTH-1:1]};
                    // Counter parks at zero on exit so it never wraps inside a frame
                    bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bus.bit_done && (bus.sampled_bit != par_exp_c)) begin
                    par_err_d   = 1'b1;
                    frame_bad_d = 1'b1;
                end
            end
            S_STOP: begin
                if (bus.bit_done) begin
                    frame_bad_d = 1'b0;
                    if (!bus.sampled_bit) begin
                        stp_err_d = 1'b1;
                    end else if (!frame_bad_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shreg_q;
                    end
                end
            end
            default: begin
                bit_cnt_d = '0;
            end
        endcase
    end

    assign bus.p_data      = p_data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.par_err     = par_err_q;
    assign bus.stp_err     = stp_err_q;
    assign bus.strt_glitch = strt_glitch_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// Self-checking bench for uart_rx_frame_deserializer: directed frame table, reset
// sequence and randomized frames against a frame-level reference model.
module tb_uart_rx_frame_deserializer;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_frame_deserializer_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_frame_deserializer #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] model_pdata;

    typedef struct {
        string         name;
        logic [DW-1:0] data;
        logic          pen;
        logic          ptyp;
        logic          sbit;
        logic          pbit;
        logic          stbit;
        logic          exp_valid;
        logic          exp_perr;
        logic          exp_serr;
        logic          exp_glitch;
        logic [DW-1:0] exp_pdata;
    } vec_t;

    vec_t tbl[6];

    // Pulse/busy vector ordering: {data_valid, par_err, stp_err, strt_glitch, busy}
    task automatic chk_vec(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch, bus.busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {valid,perr,serr,glitch,busy} got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] exp);
        checks++;
        if (bus.p_data !== exp) begin
            errors++;
            $display("FAIL %s: p_data got %h expected %h at %0t", name, bus.p_data, exp, $time);
        end
    endtask

    // Drive one clock of inputs; outputs are observed 1 time unit after the edge
    task automatic cycle(input logic fs, input logic bd, input logic sb);
        bus.frame_start = fs;
        bus.bit_done    = bd;
        bus.sampled_bit = sb;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles inside a frame: stray frame_start, bit noise and config churn must be ignored
    task automatic gaps(input int n, input string name);
        for (int g = 0; g < n; g++) begin
            bus.par_en  = 1'($urandom_range(0, 1));
            bus.par_typ = 1'($urandom_range(0, 1));
            cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            chk_vec({name, " gap"}, 5'b00001);
        end
    endtask

    task automatic send_bit(input string name, input logic sb, input logic [4:0] exp, input int maxgap);
        gaps($urandom_range(0, maxgap), name);
        cycle(1'b0, 1'b1, sb);
        chk_vec(name, exp);
    endtask

    task automatic run_frame(input vec_t v, input int maxgap);
        bus.par_en  = v.pen;
        bus.par_typ = v.ptyp;
        cycle(1'b1, 1'b0, 1'b0);
        chk_vec({v.name, " frame_start"}, 5'b00001);
        send_bit({v.name, " start"}, v.sbit, v.exp_glitch ? 5'b00010 : 5'b00001, maxgap);
        if (v.sbit) begin
            for (int k = 0; k < 3; k++) begin
                cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
                chk_vec({v.name, " ignored bit_done"}, 5'b00000);
            end
        end else begin
            for (int i = 0; i < int'(DW); i++) begin
                send_bit({v.name, " data"}, v.data[i], 5'b00001, maxgap);
            end
            if (v.pen) begin
                send_bit({v.name, " parity"}, v.pbit, {1'b0, v.exp_perr, 3'b001}, maxgap);
            end
            send_bit({v.name, " stop"}, v.stbit, {v.exp_valid, 1'b0, v.exp_serr, 2'b00}, maxgap);
        end
        chk_data({v.name, " p_data"}, v.exp_pdata);
    endtask

    initial begin
        vec_t v;
        int   ones;
        logic ok_par;

        //          name            data   pen   ptyp  sbit  pbit  stbit valid perr  serr  glitch pdata
        tbl[0] = '{"good_A5",      8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        tbl[1] = '{"parity_err",   8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        tbl[2] = '{"stop_err",     8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[3] = '{"start_glitch", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[4] = '{"b2b_55",       8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55};
        tbl[5] = '{"b2b_FF",       8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};

        bus.frame_start = 1'b0;
        bus.bit_done    = 1'b0;
        bus.sampled_bit = 1'b0;
        bus.par_en      = 1'b0;
        bus.par_typ     = 1'b0;
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk_vec("reset outputs", 5'b00000);
        chk_data("reset p_data", '0);
        rst = 1'b0;

        // Directed frames; entries 4 and 5 run back-to-back with no idle cycle
        for (int t = 0; t < 6; t++) begin
            run_frame(tbl[t], (t >= 4) ? 0 : 1);
        end

        // Reset in the middle of the data field
        bus.par_en = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        chk_vec("rst_mid frame_start", 5'b00001);
        cycle(1'b0, 1'b1, 1'b0);
        chk_vec("rst_mid start", 5'b00001);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'(i % 2));
            chk_vec("rst_mid data", 5'b00001);
        end
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk_vec("rst_mid outputs", 5'b00000);
        chk_data("rst_mid p_data", '0);
        cycle(1'b0, 1'b1, 1'b1);
        chk_vec("rst_mid idle bit_done", 5'b00000);
        run_frame('{"after_rst_81", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b0, 1'b0, 8'h81}, 1);
        model_pdata = 8'h81;

        // Randomized frames against the frame-level model
        for (int n = 0; n < 60; n++) begin
            v.name  = "random";
            v.data  = DW'($urandom);
            v.pen   = 1'($urandom_range(0, 1));
            v.ptyp  = 1'($urandom_range(0, 1));
            v.sbit  = ($urandom_range(0, 7) == 0);
            v.pbit  = 1'($urandom_range(0, 1));
            v.stbit = ($urandom_range(0, 5) != 0);
            // Even parity: data+parity ones count is even; odd parity: it is odd
            ones   = $countones(v.data) + int'(v.pbit);
            ok_par = ((ones % 2) == int'(v.ptyp));
            v.exp_glitch = v.sbit;
            v.exp_perr   = !v.sbit && v.pen && !ok_par;
            v.exp_serr   = !v.sbit && !v.stbit;
            v.exp_valid  = !v.sbit && v.stbit && !v.exp_perr;
            v.exp_pdata  = v.exp_valid ? v.data : model_pdata;
            model_pdata  = v.exp_pdata;
            run_frame(v, 2);
            if ($urandom_range(0, 1) == 1) begin
                cycle(1'b0, 1'b0, 1'b0);
                chk_vec("random idle", 5'b00000);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_deserializer.md
Name: uart_rx_frame_deserializer

Overview:
Downstream neighbour of the RX oversampling/majority-vote stage. It consumes the voted bit plus a per-bit "bit done" strobe and walks the UART frame: start, DATA_WIDTH data bits LSB-first, optional parity, stop. It checks start, parity and stop, then publishes the parallel byte with a one-cycle valid pulse to the RX top level. It also reports per-frame error pulses.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5..9)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high
frame_start  in  1  one-cycle pulse from the RX control stage when a falling edge on RX_IN is detected while idle
bit_done  in  1  one-cycle pulse; sampled_bit holds the voted value of the current bit in this cycle
sampled_bit  in  1  majority-voted bit from the sampling stage
par_en  in  1  1 = frame carries a parity bit
par_typ  in  1  0 = even, 1 = odd
p_data  out  DATA_WIDTH  last good received word
data_valid  out  1  one-cycle pulse; p_data updated in the same cycle
par_err  out  1  one-cycle pulse on parity mismatch
stp_err  out  1  one-cycle pulse on stop bit sampled 0
strt_glitch  out  1  one-cycle pulse when the start bit votes 1
busy  out  1  high while a frame is in progress

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; shift register, bit counter and latched config cleared. Outputs: p_data=0, data_valid=0, par_err=0, stp_err=0, strt_glitch=0, busy=0. Reset mid-frame aborts the frame with no error or valid pulse.
- All outputs are registered. Every pulse output is high for exactly one cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - frame_start=1 -> START; latch par_en/par_typ into frame config; busy=1 from the next cycle.
  - bit_done in IDLE is ignored.
- START, on bit_done:
  - sampled_bit=1 -> strt_glitch pulse next cycle; go to IDLE.
  - sampled_bit=0 -> DATA; bit_cnt=0.
- DATA, on bit_done:
  - shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]} (LSB-first); bit_cnt increments.
  - When bit_cnt==DATA_WIDTH-1, the shift happens and the FSM leaves DATA: to PARITY if latched par_en=1, else to STOP.
  - bit_cnt width is clog2(DATA_WIDTH); it never wraps within a frame.
- PARITY, on bit_done:
  - expected = (XOR of shreg) XOR latched par_typ.
  - sampled_bit != expected -> par_err pulse next cycle; set internal frame_bad flag.
  - Always go to STOP; the frame is completed, not aborted.
- STOP, on bit_done:
  - sampled_bit=0 -> stp_err pulse next cycle.
  - Else if frame_bad=0 -> data_valid pulse next cycle and p_data<=shreg in that same cycle.
  - Else -> no valid pulse.
  - Always go to IDLE; clear frame_bad.
- Latency: data_valid, stp_err and strt_glitch assert exactly 1 clk after the qualifying bit_done. par_err asserts 1 clk after the parity bit_done.
- busy deasserts in the same cycle as the terminating pulse (data_valid/stp_err/strt_glitch). busy stays 0 in the silent case: STOP with frame_bad=1 and stop bit=1.
- p_data holds its value on every errored frame.
- frame_start while not in IDLE: ignored.
- frame_start in the cycle the FSM returns to IDLE (the cycle data_valid is high) is accepted. This gives back-to-back frames without a gap.
- par_en/par_typ changes mid-frame have no effect; they are latched at frame_start.
- bit_done with no pending state change: no action.
- Required number of bit_done pulses per frame: 1+DATA_WIDTH+par_en+1.

Test Plan:
- Good frame, par_en=1, par_typ=0: frame_start, then bits 0 | 1,0,1,0,0,1,0,1 | parity 0 | stop 1 -> data_valid 1 clk after 11th bit_done, p_data=0xA5, no errors, busy low thereafter.
- Parity error, par_typ=1, same 0xA5 data, parity bit 0 -> par_err pulse 1 clk after 10th bit_done; no data_valid; p_data stays at its previous value (0xA5 from the first test).
- Stop error, par_en=0, data 0x3C, stop bit 0 -> stp_err 1 clk after 10th bit_done; no data_valid; p_data unchanged.
- Start glitch: frame_start, first bit_done with sampled_bit=1 -> strt_glitch pulse next cycle; busy=0; subsequent bit_done pulses ignored until the next frame_start.
- Back-to-back, par_en=0: frame 0x55 then frame_start in the data_valid cycle, frame 0xFF -> two data_valid pulses, p_data=0x55 then 0xFF; frame_start while busy is ignored.
- Reset mid-DATA, after 4 data bits: rst=1 for 1 cycle -> all outputs 0, state IDLE; the next full frame 0x81 receives correctly.
